// File: rtl/trit_pack_if.sv
// rtl/trit_pack_if.sv - trit input stream and packed byte output stream of trit_pack
interface trit_pack_if;
  logic       trit_valid;
  logic       trit_ready;
  logic [1:0] trit;
  logic       byte_valid;
  logic       byte_ready;
  logic [7:0] byte_out;
  logic       byte_last;

  // master drives trits in and takes bytes out; slave is the packer
  modport master (
    output trit_valid, trit, byte_ready,
    input  trit_ready, byte_valid, byte_out, byte_last
  );

  modport slave (
    input  trit_valid, trit, byte_ready,
    output trit_ready, byte_valid, byte_out, byte_last
  );
endinterface

// File: rtl/trit_pack.sv
// rtl/trit_pack.sv - packs five base-3 trits per byte (NTRU-HRSS encoding)
// TRIT_PACK_ERR_EN adds the sticky err output flagging accepted trit==3.
module trit_pack #(
  parameter int N = 701
) (
  input  logic       clk,
  input  logic       rst,
  trit_pack_if.slave s
`ifdef TRIT_PACK_ERR_EN
  ,
  output logic       err
`endif
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

  typedef enum logic {
    ACC  = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t        state;
  logic [7:0]    acc;
  logic [2:0]    k;
  logic [CW-1:0] cnt;

  logic          take;
  logic          give;
  logic [1:0]    t_val;
  logic [7:0]    weight;
  logic [7:0]    prod;
  logic [7:0]    sum;
  logic          end_poly;
  logic          end_byte;

  assign take = s.trit_valid && s.trit_ready;
  assign give = s.byte_valid && s.byte_ready;

  // the illegal code 3 contributes nothing to the byte
  assign t_val = (s.trit == 2'd3) ? 2'd0 : s.trit;

  always_comb begin
    weight = 8'd0;
    case (k)
      3'd0:    weight = 8'd1;
      3'd1:    weight = 8'd3;
      3'd2:    weight = 8'd9;
      3'd3:    weight = 8'd27;
      3'd4:    weight = 8'd81;
      default: weight = 8'd0;
    endcase
  end

  // trit is 0, 1 or 2, so the product is a select of weight or weight<<1
  assign prod = (t_val[0] ? weight : 8'd0)
              + (t_val[1] ? {weight[6:0], 1'b0} : 8'd0);
  assign sum      = acc + prod;
  assign end_poly = (cnt == LAST_IDX);
  assign end_byte = (k == 3'd4) || end_poly;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ACC;
      acc          <= 8'd0;
      k            <= 3'd0;
      cnt          <= '0;
      s.trit_ready <= 1'b0;
      s.byte_valid <= 1'b0;
      s.byte_out   <= 8'd0;
      s.byte_last  <= 1'b0;
    end else begin
      case (state)
        ACC: begin
          s.trit_ready <= 1'b1;
          if (take) begin
            acc <= sum;
            k   <= k + 3'd1;
            // cnt parks on the last index until the final byte leaves
            cnt <= end_poly ? cnt : cnt + CW'(1);
            if (end_byte) begin
              state        <= EMIT;
              s.trit_ready <= 1'b0;
              s.byte_valid <= 1'b1;
              s.byte_out   <= sum;
              s.byte_last  <= end_poly;
            end
          end
        end
        EMIT: begin
          if (give) begin
            state        <= ACC;
            acc          <= 8'd0;
            k            <= 3'd0;
            s.byte_valid <= 1'b0;
            s.trit_ready <= 1'b1;
            if (s.byte_last) begin
              cnt <= '0;
            end
          end
        end
      endcase
    end
  end

`ifdef TRIT_PACK_ERR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (take && (s.trit == 2'd3)) begin
      err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_trit_pack.sv
// tb/tb_trit_pack.sv - self-checking bench for trit_pack
module tb_trit_pack;
  localparam int N = 701;

  logic clk = 1'b0;
  logic rst = 1'b1;

  trit_pack_if bus ();

`ifdef TRIT_PACK_ERR_EN
  logic err;
`endif

  trit_pack #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .s   (bus.slave)
`ifdef TRIT_PACK_ERR_EN
    ,
    .err (err)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [8:0] exp_q[$];
  logic [8:0] rx_q[$];
  logic [1:0] tq[$];
  logic       mon_en = 1'b0;

  typedef struct packed {
    logic [4:0][1:0] t;
    logic [7:0]      b;
  } vec_t;

  vec_t vt[7];

  always @(negedge clk) begin
    if (mon_en && bus.byte_valid && bus.byte_ready)
      rx_q.push_back({bus.byte_last, bus.byte_out});
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.trit_valid = 1'b0;
    bus.trit = 2'd0;
    tick();
    check("rst_byte_valid_drop", bus.byte_valid, 0);
    tick();
    check("rst_trit_ready", bus.trit_ready, 0);
    check("rst_byte_out", bus.byte_out, 0);
    check("rst_byte_last", bus.byte_last, 0);
`ifdef TRIT_PACK_ERR_EN
    check("rst_err", err, 0);
`endif
    rst = 1'b0;
    @(negedge clk);
    check("ready_low_first_cycle", bus.trit_ready, 0);
    tick();
    check("ready_rises", bus.trit_ready, 1);
  endtask

  task automatic put_trit(input logic [1:0] t);
    int g = 0;
    bus.trit = t;
    bus.trit_valid = 1'b1;
    @(negedge clk);
    while (bus.trit_ready !== 1'b1 && g < 100) begin
      g++;
      @(negedge clk);
    end
    if (g >= 100) check("put_trit_timeout", 0, 1);
    tick();
    bus.trit_valid = 1'b0;
  endtask

  // reference packing: byte j = sum over i of t[5j+i] * 3^i, code 3 counts as 0
  function automatic void model(input logic [1:0] p[$]);
    int nb = (p.size() + 4) / 5;
    for (int j = 0; j < nb; j++) begin
      int v = 0;
      int w = 1;
      for (int i = 0; i < 5; i++) begin
        if (5 * j + i < p.size())
          v += ((p[5 * j + i] == 2'd3) ? 0 : int'(p[5 * j + i])) * w;
        w *= 3;
      end
      exp_q.push_back({(j == nb - 1), v[7:0]});
    end
  endfunction

  task automatic run_polys(input int mode, input int npoly, input int ready_pct, input int gap_pct);
    logic [1:0] poly[$];
    logic       stuck = 1'b0;
    int         g;
    int         c;
    int         m;
    tq.delete();
    exp_q.delete();
    rx_q.delete();
    for (int p = 0; p < npoly; p++) begin
      poly.delete();
      for (int i = 0; i < N; i++) begin
        case (mode)
          0: poly.push_back(2'd0);
          1: poly.push_back(2'd2);
          default: poly.push_back(($urandom_range(0, 49) == 0) ? 2'd3 : 2'($urandom_range(0, 2)));
        endcase
      end
      model(poly);
      foreach (poly[i]) tq.push_back(poly[i]);
    end
    mon_en = 1'b1;
    fork
      begin
        for (int i = 0; i < tq.size() && !stuck; i++) begin
          while ($urandom_range(0, 99) < gap_pct) begin
            bus.trit_valid = 1'b0;
            tick();
          end
          bus.trit = tq[i];
          bus.trit_valid = 1'b1;
          g = 0;
          @(negedge clk);
          while (bus.trit_ready !== 1'b1 && g < 200) begin
            g++;
            @(negedge clk);
          end
          if (g >= 200) begin
            check("stream_trit_timeout", 0, 1);
            stuck = 1'b1;
          end
          tick();
        end
        bus.trit_valid = 1'b0;
      end
      begin
        c = 0;
        while (rx_q.size() < exp_q.size() && c < 20000) begin
          bus.byte_ready = ($urandom_range(0, 99) < ready_pct);
          tick();
          c++;
        end
        bus.byte_ready = 1'b0;
      end
    join
    mon_en = 1'b0;
    check($sformatf("mode%0d_byte_count", mode), rx_q.size(), exp_q.size());
    m = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    for (int i = 0; i < m; i++)
      check($sformatf("mode%0d_byte%0d_{last,data}", mode, i), rx_q[i], exp_q[i]);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached before completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.trit_valid = 1'b0;
    bus.trit = 2'd0;
    bus.byte_ready = 1'b0;

    vt[0] = '{t: {2'd2, 2'd1, 2'd0, 2'd2, 2'd1}, b: 8'hC4};
    vt[1] = '{t: 10'd0,                          b: 8'h00};
    vt[2] = '{t: {5{2'd2}},                      b: 8'hF2};
    vt[3] = '{t: {2'd1, 2'd0, 2'd0, 2'd0, 2'd0}, b: 8'h51};
    vt[4] = '{t: {2'd0, 2'd0, 2'd0, 2'd1, 2'd3}, b: 8'h03};
    vt[5] = '{t: {5{2'd1}},                      b: 8'h79};
    vt[6] = '{t: {2'd2, 2'd0, 2'd2, 2'd0, 2'd2}, b: 8'hB6};

    for (int v = 0; v < 7; v++) begin
      bus.byte_ready = 1'b0;
      do_reset();
      for (int i = 0; i < 5; i++) begin
        put_trit(vt[v].t[i]);
        if (i == 3) check($sformatf("v%0d_no_early_valid", v), bus.byte_valid, 0);
      end
      check($sformatf("v%0d_valid", v), bus.byte_valid, 1);
      check($sformatf("v%0d_byte", v), bus.byte_out, vt[v].b);
      check($sformatf("v%0d_last", v), bus.byte_last, 0);
      check($sformatf("v%0d_ready_low", v), bus.trit_ready, 0);
      bus.byte_ready = 1'b1;
      tick();
      bus.byte_ready = 1'b0;
      check($sformatf("v%0d_valid_drop", v), bus.byte_valid, 0);
      check($sformatf("v%0d_ready_back", v), bus.trit_ready, 1);
    end

    // backpressure: byte held 10 cycles while a trit is offered
    do_reset();
    put_trit(2'd1); put_trit(2'd2); put_trit(2'd0); put_trit(2'd1); put_trit(2'd2);
    bus.trit = 2'd2;
    bus.trit_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("stall_byte", bus.byte_out, 8'hC4);
      check("stall_valid", bus.byte_valid, 1);
      check("stall_ready", bus.trit_ready, 0);
    end
    bus.trit_valid = 1'b0;
    bus.byte_ready = 1'b1;
    tick();
    bus.byte_ready = 1'b0;
    check("release_valid", bus.byte_valid, 0);
    check("release_ready", bus.trit_ready, 1);
    for (int i = 0; i < 5; i++) put_trit(2'd0);
    check("after_stall_byte", bus.byte_out, 8'h00);

    // reset mid-byte leaves no residue; reset with a pending byte drops it
    do_reset();
    put_trit(2'd1); put_trit(2'd1); put_trit(2'd1);
    do_reset();
    put_trit(2'd2); put_trit(2'd0); put_trit(2'd0); put_trit(2'd0); put_trit(2'd0);
    check("post_rst_valid", bus.byte_valid, 1);
    check("post_rst_byte", bus.byte_out, 8'h02);

`ifdef TRIT_PACK_ERR_EN
    do_reset();
    check("err_clear", err, 0);
    put_trit(2'd3);
    check("err_set", err, 1);
    put_trit(2'd1); put_trit(2'd0); put_trit(2'd0); put_trit(2'd0);
    check("err_byte", bus.byte_out, 8'h03);
    bus.byte_ready = 1'b1;
    tick();
    bus.byte_ready = 1'b0;
    for (int i = 0; i < 5; i++) put_trit(2'd1);
    check("err_sticky", err, 1);
`endif

    do_reset();
    run_polys(0, 2, 100, 0);
    run_polys(1, 1, 100, 0);
    run_polys(2, 2, 60, 25);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
